pipe_ctrl: RTL and testbench

//  Pipelined control unit for the RISC core: decodes the ID-stage opcode into a control bundle and

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipe_ctrl_if.sv | 44 ++++
 rtl/pipe_ctrl_decode.sv | 51 +++++
 rtl/pipe_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - control-bundle layout, opcodes and hazard event encoding
package pipe_ctrl_pkg;

    localparam int CTRL_W          = 7;
    localparam int CTRL_WEN        = 6;
    localparam int CTRL_MEM_READ   = 5;
    localparam int CTRL_MEM_WRITE  = 4;
    localparam int CTRL_ALU_TO_REG = 3;
    localparam int CTRL_BRANCH     = 2;
    localparam int CTRL_JR         = 1;
    localparam int CTRL_JAL        = 0;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_JR  = 4'hA;
    localparam logic [3:0] OP_JAL = 4'hB;
    localparam logic [3:0] OP_BNE = 4'hC;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_LOAD_USE,
        EV_REDIRECT,
        EV_FREEZE
    } pipe_event_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - ID inputs, datapath status and pipeline control outputs
interface pipe_ctrl_if #(
    parameter int OPCODE_W = 4,
    parameter int RADDR_W  = 3,
    parameter int CNT_W    = 16
);
    import pipe_ctrl_pkg::*;

    logic                id_valid;
    logic [OPCODE_W-1:0] id_opcode;
    logic [RADDR_W-1:0]  id_rs1;
    logic [RADDR_W-1:0]  id_rs2;
    logic [RADDR_W-1:0]  id_rd;
    logic                ex_redirect;
    logic                mem_ready;

    logic                stall_if;
    logic                flush_id;
    logic                ex_valid;
    logic [CTRL_W-1:0]   ex_ctrl;
    logic [RADDR_W-1:0]  ex_rd;
    logic                mem_valid;
    logic [CTRL_W-1:0]   mem_ctrl;
    logic [RADDR_W-1:0]  mem_rd;
    logic                wb_valid;
    logic                wb_wen;
    logic                wb_alu_to_reg;
    logic [RADDR_W-1:0]  wb_rd;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    flush_cnt;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect, mem_ready,
        input  stall_if, flush_id, ex_valid, ex_ctrl, ex_rd, mem_valid, mem_ctrl, mem_rd,
               wb_valid, wb_wen, wb_alu_to_reg, wb_rd, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect, mem_ready,
        output stall_if, flush_id, ex_valid, ex_ctrl, ex_rd, mem_valid, mem_ctrl, mem_rd,
               wb_valid, wb_wen, wb_alu_to_reg, wb_rd, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_ctrl_decode.sv
// rtl/pipe_ctrl_decode.sv - combinational opcode to control-bundle table
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int RADDR_W  = 3,
    parameter int ZERO_REG = 1
) (
    input  logic                i_valid,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic [RADDR_W-1:0]  i_rd,
    output logic [CTRL_W-1:0]   o_ctrl
);

    always_comb begin
        // Anything not listed behaves as a register-writing ALU op
        o_ctrl                  = '0;
        o_ctrl[CTRL_WEN]        = 1'b1;
        o_ctrl[CTRL_ALU_TO_REG] = 1'b1;
        case (i_opcode)
            OPCODE_W'(OP_LW): begin
                o_ctrl[CTRL_MEM_READ]   = 1'b1;
                o_ctrl[CTRL_ALU_TO_REG] = 1'b0;
            end
            OPCODE_W'(OP_SW): begin
                o_ctrl[CTRL_WEN]       = 1'b0;
                o_ctrl[CTRL_MEM_WRITE] = 1'b1;
            end
            OPCODE_W'(OP_JR): begin
                o_ctrl[CTRL_WEN] = 1'b0;
                o_ctrl[CTRL_JR]  = 1'b1;
            end
            OPCODE_W'(OP_JAL): begin
                o_ctrl[CTRL_JR]  = 1'b1;
                o_ctrl[CTRL_JAL] = 1'b1;
            end
            OPCODE_W'(OP_BNE): begin
                o_ctrl[CTRL_WEN]    = 1'b0;
                o_ctrl[CTRL_BRANCH] = 1'b1;
            end
            default: ;
        endcase
        if ((ZERO_REG != 0) && (i_rd == '0)) begin
            o_ctrl[CTRL_WEN] = 1'b0;
        end
        if (!i_valid) begin
            o_ctrl = '0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - EX/MEM/WB control pipeline with stall, flush, freeze and counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int RADDR_W  = 3,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);

    logic [CTRL_W-1:0]  w_id_ctrl;
    logic               w_freeze;
    logic               w_redirect;
    logic               w_load_use;
    logic               w_ex_hit;
    logic               w_ex_zero;
    logic               w_stall;
    pipe_event_e        w_event;

    logic               r_ex_valid;
    logic [CTRL_W-1:0]  r_ex_ctrl;
    logic [RADDR_W-1:0] r_ex_rd;
    logic               r_mem_valid;
    logic [CTRL_W-1:0]  r_mem_ctrl;
    logic [RADDR_W-1:0] r_mem_rd;
    logic               r_wb_valid;
    logic               r_wb_wen;
    logic               r_wb_alu;
    logic [RADDR_W-1:0] r_wb_rd;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    pipe_ctrl_decode #(
        .OPCODE_W (OPCODE_W),
        .RADDR_W  (RADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_decode (
        .i_valid  (bus.id_valid),
        .i_opcode (bus.id_opcode),
        .i_rd     (bus.id_rd),
        .o_ctrl   (w_id_ctrl)
    );

    assign w_freeze   = r_mem_valid & (r_mem_ctrl[CTRL_MEM_READ] | r_mem_ctrl[CTRL_MEM_WRITE])
                      & ~bus.mem_ready;
    assign w_redirect = r_ex_valid & bus.ex_redirect & ~w_freeze;
    assign w_ex_hit   = (r_ex_rd == bus.id_rs1) | (r_ex_rd == bus.id_rs2);
    assign w_ex_zero  = (ZERO_REG != 0) && (r_ex_rd == '0);
    assign w_load_use = r_ex_valid & r_ex_ctrl[CTRL_MEM_READ] & bus.id_valid & w_ex_hit
                      & ~w_ex_zero & ~w_freeze & ~w_redirect;
    assign w_stall    = w_freeze | w_load_use;

    always_comb begin
        w_event = EV_NONE;
        if (w_freeze)        w_event = EV_FREEZE;
        else if (w_redirect) w_event = EV_REDIRECT;
        else if (w_load_use) w_event = EV_LOAD_USE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_ctrl   <= '0;
            r_ex_rd     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_ctrl  <= '0;
            r_mem_rd    <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_wen    <= 1'b0;
            r_wb_alu    <= 1'b0;
            r_wb_rd     <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            case (w_event)
                // WB retires its instruction once, then idles while MEM waits
                EV_FREEZE: r_wb_valid <= 1'b0;
                default: begin
                    r_wb_valid  <= r_mem_valid;
                    r_wb_wen    <= r_mem_ctrl[CTRL_WEN];
                    r_wb_alu    <= r_mem_ctrl[CTRL_ALU_TO_REG];
                    r_wb_rd     <= r_mem_rd;
                    r_mem_valid <= r_ex_valid;
                    r_mem_ctrl  <= r_ex_ctrl;
                    r_mem_rd    <= r_ex_rd;
                    if (w_event == EV_NONE) begin
                        r_ex_valid <= bus.id_valid;
                        r_ex_ctrl  <= w_id_ctrl;
                        r_ex_rd    <= bus.id_valid ? bus.id_rd : '0;
                    end else begin
                        r_ex_valid <= 1'b0;
                        r_ex_ctrl  <= '0;
                        r_ex_rd    <= '0;
                    end
                end
            endcase
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign bus.stall_if      = w_stall;
    assign bus.flush_id      = w_redirect;
    assign bus.ex_valid      = r_ex_valid;
    assign bus.ex_ctrl       = r_ex_ctrl;
    assign bus.ex_rd         = r_ex_rd;
    assign bus.mem_valid     = r_mem_valid;
    assign bus.mem_ctrl      = r_mem_ctrl;
    assign bus.mem_rd        = r_mem_rd;
    assign bus.wb_valid      = r_wb_valid;
    assign bus.wb_wen        = r_wb_valid & r_wb_wen;
    assign bus.wb_alu_to_reg = r_wb_alu;
    assign bus.wb_rd         = r_wb_rd;
    assign bus.stall_cnt     = r_stall_cnt;
    assign bus.flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam logic [6:0] C_ALU = 7'b1001000;
    localparam logic [6:0] C_SW  = 7'b0011000;
    localparam logic [6:0] C_BNE = 7'b0001100;
    localparam logic [6:0] C_JAL = 7'b1001011;
    localparam logic [6:0] C_JL0 = 7'b0001011;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    pipe_ctrl_if #(.OPCODE_W(4), .RADDR_W(3), .CNT_W(16)) bus ();
    pipe_ctrl_if #(.OPCODE_W(4), .RADDR_W(3), .CNT_W(4))  bus_s ();

    pipe_ctrl #(.OPCODE_W(4), .RADDR_W(3), .ZERO_REG(1), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pipe_ctrl #(.OPCODE_W(4), .RADDR_W(3), .ZERO_REG(1), .CNT_W(4)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [2:0] rd,
                         input logic redir, input logic ready);
        bus.id_valid    = v;
        bus.id_opcode   = op;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.ex_redirect = redir;
        bus.mem_ready   = ready;
    endtask

    task automatic idle();
        drive(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        bus_s.id_valid = 1'b0; bus_s.id_opcode = OP_ADD; bus_s.id_rs1 = 3'd0;
        bus_s.id_rs2 = 3'd0; bus_s.id_rd = 3'd0; bus_s.ex_redirect = 1'b0; bus_s.mem_ready = 1'b1;
        repeat (2) tick();
        check("rst_ex_valid", bus.ex_valid, 0);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_stall_if", bus.stall_if, 0);
        check("rst_stall_cnt", bus.stall_cnt, 0);
        rst_n = 1'b1;

        // ALU rd=2 then SW
        drive(1'b1, OP_ADD, 3'd1, 3'd1, 3'd2, 1'b0, 1'b1);
        tick();
        check("alu_ex_ctrl", bus.ex_ctrl, C_ALU);
        check("alu_ex_rd", bus.ex_rd, 2);
        drive(1'b1, OP_SW, 3'd2, 3'd1, 3'd5, 1'b0, 1'b1);
        #1 check("alu_sw_no_stall", bus.stall_if, 0);
        tick();
        check("sw_ex_ctrl", bus.ex_ctrl, C_SW);
        check("alu_mem_rd", bus.mem_rd, 2);
        idle();
        tick();
        check("alu_wb_wen", bus.wb_wen, 1);
        check("alu_wb_rd", bus.wb_rd, 2);
        tick();
        check("sw_wb_valid", bus.wb_valid, 1);
        check("sw_wb_wen", bus.wb_wen, 0);
        check("t1_stall_cnt", bus.stall_cnt, 0);
        repeat (2) tick();

        // load-use
        drive(1'b1, OP_LW, 3'd1, 3'd1, 3'd3, 1'b0, 1'b1);
        tick();
        check("lw_ex_ctrl", bus.ex_ctrl, 7'b1100000);
        drive(1'b1, OP_ADD, 3'd3, 3'd4, 3'd5, 1'b0, 1'b1);
        #1 check("lu_stall_if", bus.stall_if, 1);
        tick();
        check("lu_ex_bubble", bus.ex_valid, 0);
        check("lu_stall_once", bus.stall_if, 0);
        check("lu_mem_rd", bus.mem_rd, 3);
        tick();
        check("lu_add_ex_valid", bus.ex_valid, 1);
        check("lu_add_ex_rd", bus.ex_rd, 5);
        check("lu_stall_cnt", bus.stall_cnt, 1);
        idle();
        repeat (3) tick();

        // BNE redirect
        drive(1'b1, OP_BNE, 3'd1, 3'd2, 3'd0, 1'b0, 1'b1);
        tick();
        check("bne_ex_ctrl", bus.ex_ctrl, C_BNE);
        drive(1'b1, OP_ADD, 3'd1, 3'd1, 3'd4, 1'b1, 1'b1);
        #1 check("br_flush_id", bus.flush_id, 1);
        check("br_stall_if", bus.stall_if, 0);
        tick();
        drive(1'b1, OP_ADD, 3'd1, 3'd1, 3'd6, 1'b0, 1'b1);
        #1 check("br_flush_once", bus.flush_id, 0);
        check("br_ex_bubble", bus.ex_valid, 0);
        check("br_mem_ctrl", bus.mem_ctrl, C_BNE);
        check("br_flush_cnt", bus.flush_cnt, 1);
        tick();
        check("br_target_ex_rd", bus.ex_rd, 6);
        idle();
        repeat (3) tick();

        // memory-wait freeze, 3 cycles
        drive(1'b1, OP_LW, 3'd1, 3'd1, 3'd4, 1'b0, 1'b1);
        tick();
        drive(1'b1, OP_ADD, 3'd1, 3'd2, 3'd6, 1'b0, 1'b1);
        tick();
        drive(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0);
        #1 check("fz_stall_if", bus.stall_if, 1);
        repeat (3) tick();
        check("fz_mem_rd_hold", bus.mem_rd, 4);
        check("fz_ex_rd_hold", bus.ex_rd, 6);
        check("fz_wb_valid", bus.wb_valid, 0);
        check("fz_stall_cnt", bus.stall_cnt, 4);
        bus.mem_ready = 1'b1;
        #1 check("fz_release", bus.stall_if, 0);
        tick();
        check("fz_lw_wb_wen", bus.wb_wen, 1);
        check("fz_lw_wb_rd", bus.wb_rd, 4);
        check("fz_lw_wb_sel", bus.wb_alu_to_reg, 0);
        tick();
        check("fz_lw_once", bus.wb_rd, 6);
        idle();
        repeat (2) tick();

        // JAL link with redirect, then rd=0 variant
        drive(1'b1, OP_JAL, 3'd0, 3'd0, 3'd7, 1'b0, 1'b1);
        tick();
        check("jal_ex_ctrl", bus.ex_ctrl, C_JAL);
        drive(1'b0, OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1);
        #1 check("jal_flush_id", bus.flush_id, 1);
        tick();
        idle();
        tick();
        check("jal_wb_wen", bus.wb_wen, 1);
        check("jal_wb_rd", bus.wb_rd, 7);
        check("jal_wb_sel", bus.wb_alu_to_reg, 1);
        check("jal_flush_cnt", bus.flush_cnt, 2);
        drive(1'b1, OP_JAL, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1);
        tick();
        check("jal0_ex_ctrl", bus.ex_ctrl, C_JL0);
        idle();
        repeat (2) tick();
        check("jal0_wb_valid", bus.wb_valid, 1);
        check("jal0_wb_wen", bus.wb_wen, 0);
        repeat (2) tick();

        // async reset during freeze
        drive(1'b1, OP_LW, 3'd1, 3'd1, 3'd1, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        bus.mem_ready = 1'b0;
        #1 check("rf_stall_if", bus.stall_if, 1);
        #2 rst_n = 1'b0;
        #1 check("rf_stall_if_clr", bus.stall_if, 0);
        check("rf_mem_valid", bus.mem_valid, 0);
        check("rf_mem_ctrl", bus.mem_ctrl, 0);
        check("rf_stall_cnt", bus.stall_cnt, 0);
        check("rf_flush_cnt", bus.flush_cnt, 0);
        idle();
        tick();
        rst_n = 1'b1;

        // counter saturation on the narrow-counter instance
        bus_s.id_valid = 1'b1; bus_s.id_opcode = OP_LW; bus_s.id_rd = 3'd1;
        tick();
        bus_s.id_valid = 1'b0;
        tick();
        bus_s.mem_ready = 1'b0;
        repeat (14) tick();
        check("sat_cnt_14", bus_s.stall_cnt, 14);
        repeat (6) tick();
        check("sat_cnt_max", bus_s.stall_cnt, 4'hF);
        check("sat_mem_hold", bus_s.mem_valid, 1);
        check("sat_main_idle", bus.stall_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
